// File: rtl/debounce_edge_if.sv
// debounce_edge_if -- groups the data side of the debouncer.
//   d_i         raw, possibly bouncing input (driven by the master)
//   level_o     debounced level
//   rise_o      one-cycle pulse on an accepted 0->1 change
//   fall_o      one-cycle pulse on an accepted 1->0 change
//   glitch_o    one-cycle pulse when a pending change is abandoned
//   edge_cnt_o  wrapping count of accepted changes
// The master modport is the side that drives d_i.
// The slave modport is the debouncer itself.
interface debounce_edge_if;
  logic       d_i;
  logic       level_o;
  logic       rise_o;
  logic       fall_o;
  logic       glitch_o;
  logic [7:0] edge_cnt_o;

  modport master (
    output d_i,
    input  level_o, rise_o, fall_o, glitch_o, edge_cnt_o
  );

  modport slave (
    input  d_i,
    output level_o, rise_o, fall_o, glitch_o, edge_cnt_o
  );
endinterface

// File: rtl/debounce_edge.sv
// debounce_edge -- synchronizes and debounces an asynchronous input.
// A new level is accepted only after STABLE_CYCLES consecutive disagreeing
// synchronized samples. The module also reports the following:
//   - the accepted edges
//   - abandoned (glitch) attempts
//   - a wrapping count of accepted edges
// Ports:
//   clk    single clock, all state changes on posedge
//   reset  synchronous, active-low reset
//   bus    debounce_edge_if.slave (d_i in; level/rise/fall/glitch/edge_cnt out)
// Parameters:
//   SYNC_STAGES    synchronizer depth, 2..4
//   STABLE_CYCLES  disagreeing samples needed to accept a change, 2..255
module debounce_edge #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  debounce_edge_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       glitch_q, glitch_d;
  logic [7:0] edge_cnt_q, edge_cnt_d;

  // Bit 0 takes the raw input; the top bit is the metastability-safe sample.
  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.d_i};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      glitch_q   <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      glitch_q   <= glitch_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // IDLE always has cnt == 0 and PENDING has cnt > 0.
  // Acceptance can only come from PENDING because CNT_LAST >= 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_d   = 1'b0;
    edge_cnt_d = edge_cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync_s != level_q) begin
          cnt_d   = 8'd1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (sync_s == level_q) begin
          // The input fell back before the count completed, so drop the change.
          cnt_d    = '0;
          glitch_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          level_d    = sync_s;
          cnt_d      = '0;
          rise_d     = sync_s;
          fall_d     = ~sync_s;
          edge_cnt_d = edge_cnt_q + 8'd1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.level_o    = level_q;
  assign bus.rise_o     = rise_q;
  assign bus.fall_o     = fall_q;
  assign bus.glitch_o   = glitch_q;
  assign bus.edge_cnt_o = edge_cnt_q;

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on d_i; legal range 2..4.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive disagreeing samples required to accept a new level; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-005 d_i  input  1  raw data input, asynchronous to clk, may bounce.
REQ-006 level_o  output  1  debounced, registered level of d_i.
REQ-007 rise_o  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-008 fall_o  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-009 glitch_o  output  1  one-cycle pulse when a pending change is abandoned.
REQ-010 edge_cnt_o  output  8  count of accepted changes, rise and fall both counted.

Function
REQ-011 Synchronizer: d_i SHALL pass through a SYNC_STAGES-deep flop chain; sync_s denotes the last stage.
REQ-012 Debounce counter cnt: 8 bits, internal.
REQ-013 If sync_s != level_o and cnt < STABLE_CYCLES-1, cnt SHALL increment.
REQ-014 If sync_s != level_o and cnt == STABLE_CYCLES-1: level_o <= sync_s and cnt <= 0.
REQ-015 If sync_s == level_o: cnt <= 0.
REQ-016 Acceptance latency: a d_i change held stable SHALL appear on level_o exactly SYNC_STAGES+STABLE_CYCLES posedges after the first posedge that samples it (6 with defaults).
REQ-017 rise_o / fall_o SHALL be registered and high during exactly the first cycle level_o shows the new value; never both high together.
REQ-018 glitch_o SHALL pulse for one cycle, registered, when sync_s == level_o while cnt != 0; no change to level_o.
REQ-019 A single-sample d_i pulse SHALL never reach level_o (STABLE_CYCLES >= 2).
REQ-020 edge_cnt_o SHALL increment by 1 on every rise_o or fall_o cycle; it wraps 255 -> 0 without saturating.
REQ-021 Simultaneous events: glitch_o and rise_o/fall_o SHALL be mutually exclusive in any cycle.
REQ-022 State: IDLE (cnt == 0) -> PENDING (cnt > 0) on disagreement; PENDING -> IDLE with level update on count completion; PENDING -> IDLE with glitch_o on agreement.

Reset
REQ-023 While reset == 0 at posedge clk, the following SHALL all be 0: synchronizer flops, cnt, level_o, rise_o, fall_o, glitch_o, and edge_cnt_o.
REQ-024 Reset SHALL override every other update in the same cycle, including a completing count; no pulse SHALL be emitted for that cycle.
REQ-025 After release, a d_i of 1 SHALL need the full REQ-016 latency before level_o = 1.

Verification
REQ-026 Reset: d_i = 1 and reset = 0 for 3 cycles -> every output 0 and edge_cnt_o = 0 each cycle.
REQ-027 Clean rise (defaults): d_i 0->1 held 10 cycles -> level_o = 1 at the 6th posedge, rise_o high one cycle, edge_cnt_o = 1.
REQ-028 Glitch: d_i high for 2 sampled cycles, then low -> level_o stays 0, one glitch_o pulse, edge_cnt_o unchanged.
REQ-029 Fall: from level_o = 1, d_i -> 0 held -> fall_o pulse at the 6th posedge, level_o = 0, edge_cnt_o incremented by 1.
REQ-030 Mid-count reset: d_i rises, reset = 0 when cnt = 2 -> no rise_o and level_o = 0; after release with d_i = 1, rise_o follows 6 posedges later.
REQ-031 Wrap: 256 accepted changes -> edge_cnt_o passes 255 -> 0; the bench SHALL also confirm that a 1-cycle d_i bounce never reaches level_o, for any SYNC_STAGES or STABLE_CYCLES setting used.
